// File: rtl/load_align_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | load_align_stage_pkg : word/byte types, load funct3 codes, load metadata   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package load_align_stage_pkg;

  localparam int c_WORD_BITS       = 32;
  localparam int c_BYTE_BITS       = 8;
  localparam int c_HALF_BITS       = 16;
  localparam int c_RD_BITS_DEFAULT = 5;

  typedef logic [c_WORD_BITS-1:0] word_t;
  typedef logic [c_HALF_BITS-1:0] half_t;
  typedef logic [c_BYTE_BITS-1:0] byte_t;

  localparam logic [2:0] c_F3_LB  = 3'b000;
  localparam logic [2:0] c_F3_LH  = 3'b001;
  localparam logic [2:0] c_F3_LW  = 3'b010;
  localparam logic [2:0] c_F3_LBU = 3'b100;
  localparam logic [2:0] c_F3_LHU = 3'b101;

  typedef struct packed {
    logic                         valid;
    logic [2:0]                   funct3;
    logic [1:0]                   addr_low;
    logic [c_RD_BITS_DEFAULT-1:0] rd;
  } load_meta_t;

endpackage

`default_nettype wire

// File: rtl/load_align_stage_load_extend.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | load_extend : combinational byte/half/word select with sign/zero extension |
// | Optional trap on misaligned LH/LHU/LW: LOAD_MISALIGN_TRAP_EN. Revision 1.0 |
// +----------------------------------------------------------------------------+
module load_extend
  import load_align_stage_pkg::*;
(
  input  word_t      word_i,
  input  logic [2:0] funct3_i,
  input  logic [1:0] addr_low_i,
  output word_t      value_o,
  output logic       misaligned_o
);

  byte_t w_byte;
  half_t w_half;
  logic  w_mis;

  always_comb begin
    w_byte = word_i[7:0];
    case (addr_low_i)
      2'd0: w_byte = word_i[7:0];
      2'd1: w_byte = word_i[15:8];
      2'd2: w_byte = word_i[23:16];
      2'd3: w_byte = word_i[31:24];
      default: w_byte = word_i[7:0];
    endcase
    // Without the trap, a halfword ignores addr_low[0].
    w_half = addr_low_i[1] ? word_i[31:16] : word_i[15:0];
  end

  always_comb begin
    w_mis = 1'b0;
`ifdef LOAD_MISALIGN_TRAP_EN
    case (funct3_i)
      c_F3_LH, c_F3_LHU: w_mis = addr_low_i[0];
      c_F3_LW:           w_mis = |addr_low_i;
      default:           w_mis = 1'b0;
    endcase
`endif
    value_o = '0;
    if (!w_mis) begin
      case (funct3_i)
        c_F3_LB:  value_o = {{(c_WORD_BITS-c_BYTE_BITS){w_byte[7]}}, w_byte};
        c_F3_LH:  value_o = {{(c_WORD_BITS-c_HALF_BITS){w_half[15]}}, w_half};
        c_F3_LW:  value_o = word_i;
        c_F3_LBU: value_o = {{(c_WORD_BITS-c_BYTE_BITS){1'b0}}, w_byte};
        c_F3_LHU: value_o = {{(c_WORD_BITS-c_HALF_BITS){1'b0}}, w_half};
        default:  value_o = '0;
      endcase
    end
    misaligned_o = w_mis;
  end

endmodule

`default_nettype wire

// File: rtl/load_align_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | load_align_stage : aligns load metadata with data-memory read data, holds  |
// | the word across stalls, registers the extended writeback result.          |
// | Optional misaligned trap: LOAD_MISALIGN_TRAP_EN. Revision 1.0              |
// +----------------------------------------------------------------------------+
module load_align_stage
  import load_align_stage_pkg::*;
#(
  parameter int MEM_LATENCY = 2,
  parameter int RD_BITS     = c_RD_BITS_DEFAULT
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               stall,
  input  logic               flush,
  input  logic               in_load,
  input  logic [2:0]         in_funct3,
  input  logic [1:0]         in_addr_low,
  input  logic [RD_BITS-1:0] in_rd,
  input  word_t              mem_read_value,
  output logic               out_valid,
  output logic [RD_BITS-1:0] out_rd,
  output word_t              out_value,
  output logic               out_misaligned
);

  load_meta_t         pipe_q [MEM_LATENCY];
  load_meta_t         pipe_d [MEM_LATENCY];
  logic               hold_valid_q, hold_valid_d;
  word_t              hold_data_q, hold_data_d;
  logic               out_valid_q, out_valid_d;
  logic [RD_BITS-1:0] out_rd_q, out_rd_d;
  word_t              out_value_q, out_value_d;
  logic               out_mis_q, out_mis_d;

  load_meta_t w_tail;
  word_t      w_src_word;
  word_t      w_ext_value;
  logic       w_ext_mis;

  // The last metadata stage lines up with the word memory returns this cycle.
  assign w_tail     = pipe_q[MEM_LATENCY-1];
  assign w_src_word = hold_valid_q ? hold_data_q : mem_read_value;

  load_extend u_load_extend (
    .word_i       (w_src_word),
    .funct3_i     (w_tail.funct3),
    .addr_low_i   (w_tail.addr_low),
    .value_o      (w_ext_value),
    .misaligned_o (w_ext_mis)
  );

  always_comb begin
    pipe_d       = pipe_q;
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    out_valid_d  = out_valid_q;
    out_rd_d     = out_rd_q;
    out_value_d  = out_value_q;
    out_mis_d    = out_mis_q;

    if (flush) begin
      for (int i = 0; i < MEM_LATENCY; i++) begin
        pipe_d[i].valid = 1'b0;
      end
      hold_valid_d = 1'b0;
      out_valid_d  = 1'b0;
    end else if (!stall) begin
      pipe_d[0].valid    = in_load;
      pipe_d[0].funct3   = in_funct3;
      pipe_d[0].addr_low = in_addr_low;
      pipe_d[0].rd       = in_rd;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        pipe_d[i] = pipe_q[i-1];
      end
      hold_valid_d = 1'b0;
      out_valid_d  = w_tail.valid;
      if (w_tail.valid) begin
        out_rd_d    = w_tail.rd;
        out_value_d = w_ext_value;
        out_mis_d   = w_ext_mis;
      end
    end else if (w_tail.valid && !hold_valid_q) begin
      // Memory has no enable, so its output drifts while we are held.
      hold_valid_d = 1'b1;
      hold_data_d  = mem_read_value;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < MEM_LATENCY; i++) begin
        pipe_q[i] <= '0;
      end
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      out_valid_q  <= 1'b0;
      out_rd_q     <= '0;
      out_value_q  <= '0;
      out_mis_q    <= 1'b0;
    end else begin
      pipe_q       <= pipe_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      out_valid_q  <= out_valid_d;
      out_rd_q     <= out_rd_d;
      out_value_q  <= out_value_d;
      out_mis_q    <= out_mis_d;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_rd         = out_rd_q;
  assign out_value      = out_value_q;
  assign out_misaligned = out_mis_q;

endmodule

`default_nettype wire

// File: tb/tb_load_align_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_load_align_stage : directed + randomized bench against a timeline model |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_load_align_stage;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        in_load = 1'b0;
  logic [2:0]  in_funct3 = 3'd0;
  logic [1:0]  in_addr_low = 2'd0;
  logic [4:0]  in_rd = 5'd0;
  logic [31:0] mem_read_value = 32'd0;
  logic        out_valid;
  logic [4:0]  out_rd;
  logic [31:0] out_value;
  logic        out_misaligned;

  load_align_stage #(.MEM_LATENCY(2), .RD_BITS(5)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .stall          (stall),
    .flush          (flush),
    .in_load        (in_load),
    .in_funct3      (in_funct3),
    .in_addr_low    (in_addr_low),
    .in_rd          (in_rd),
    .mem_read_value (mem_read_value),
    .out_valid      (out_valid),
    .out_rd         (out_rd),
    .out_value      (out_value),
    .out_misaligned (out_misaligned)
  );

  always #5 clock = ~clock;

  int          tests = 0;
  int          fails = 0;
  logic [31:0] last_val = 32'd0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Returns {misaligned, value} straight from the load rules.
  function automatic logic [32:0] ref_load(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] al);
    logic [31:0] b, h, v;
    logic        mis;
    b   = (w >> (8 * al)) & 32'hFF;
    h   = (w >> (16 * (al / 2))) & 32'hFFFF;
    mis = 1'b0;
    case (f3)
      3'd0:    v = b - ((b & 32'h80) << 1);
      3'd1:    v = h - ((h & 32'h8000) << 1);
      3'd2:    v = w;
      3'd4:    v = b;
      3'd5:    v = h;
      default: v = 32'd0;
    endcase
`ifdef LOAD_MISALIGN_TRAP_EN
    if (((f3 == 3'd1 || f3 == 3'd5) && al[0]) || (f3 == 3'd2 && al != 2'd0)) begin
      mis = 1'b1;
      v   = 32'd0;
    end
`endif
    return {mis, v};
  endfunction

  localparam int N = 64;
  logic        sv  [N];
  logic [2:0]  sf3 [N];
  logic [1:0]  sal [N];
  logic [4:0]  srd [N];
  logic [31:0] sw  [N];
  logic        sfl [N];

  function automatic logic fl_at(input int k, input int n);
    return (k >= 0 && k < n) ? sfl[k] : 1'b0;
  endfunction

  task automatic clear_seq();
    for (int i = 0; i < N; i++) begin
      sv[i] = 1'b0; sf3[i] = 3'd0; sal[i] = 2'd0; srd[i] = 5'd0; sw[i] = 32'd0; sfl[i] = 1'b0;
    end
  endtask

  // No-stall stream: a load issued in cycle c shows in cycle c+3 unless a
  // flush lands in cycles c..c+2; its word is on the memory bus in cycle c+2.
  task automatic run_seq(input string tag, input int n);
    for (int t = 0; t < n + 3; t++) begin
      logic        ev;
      logic [32:0] r;
      int          c;
      @(posedge clock); #1;
      stall          = 1'b0;
      in_load        = (t < n) ? sv[t] : 1'b0;
      in_funct3      = (t < n) ? sf3[t] : 3'($urandom);
      in_addr_low    = (t < n) ? sal[t] : 2'($urandom);
      in_rd          = (t < n) ? srd[t] : 5'($urandom);
      flush          = fl_at(t, n);
      mem_read_value = (t >= 2 && t - 2 < n && sv[t-2]) ? sw[t-2] : $urandom();
      @(negedge clock);
      c  = t - 3;
      ev = (c >= 0) && sv[c] && !fl_at(c, n) && !fl_at(c + 1, n) && !fl_at(c + 2, n);
      check({tag, " valid"}, 32'(out_valid), 32'(ev));
      if (ev) begin
        r = ref_load(sw[c], sf3[c], sal[c]);
        check({tag, " rd"}, 32'(out_rd), 32'(srd[c]));
        check({tag, " value"}, out_value, r[31:0]);
        check({tag, " misaligned"}, 32'(out_misaligned), 32'(r[32]));
        last_val = r[31:0];
      end
    end
    in_load = 1'b0;
    flush   = 1'b0;
  endtask

  // Single load, stalled k cycles while it waits in the last stage; memory
  // shows garbage after the one cycle the real word is valid.
  task automatic stall_load(input string tag, input logic [31:0] w, input logic [2:0] f3,
                            input logic [1:0] al, input logic [4:0] rd, input int k,
                            input logic [31:0] exp_v, input logic exp_m);
    for (int t = 0; t <= k + 4; t++) begin
      @(posedge clock); #1;
      in_load        = (t == 0);
      in_funct3      = f3;
      in_addr_low    = al;
      in_rd          = rd;
      flush          = 1'b0;
      stall          = (t >= 2 && t <= k + 1);
      mem_read_value = (t == 2) ? w : ((t > 2) ? 32'hDEADBEEF : $urandom());
      @(negedge clock);
      if (t == k + 3) begin
        check({tag, " valid"}, 32'(out_valid), 32'd1);
        check({tag, " rd"}, 32'(out_rd), 32'(rd));
        check({tag, " value"}, out_value, exp_v);
        check({tag, " misaligned"}, 32'(out_misaligned), 32'(exp_m));
        last_val = exp_v;
      end else begin
        check({tag, " idle"}, 32'(out_valid), 32'd0);
        if (t >= 3 && t <= k + 2) check({tag, " held"}, out_value, last_val);
      end
    end
    stall = 1'b0;
  endtask

  initial begin
    logic [32:0] r;
    int          k;
    logic [31:0] w;
    logic [2:0]  f3;
    logic [1:0]  al;

    // Reset state
    repeat (2) @(posedge clock);
    @(negedge clock);
    check("reset valid", 32'(out_valid), 32'd0);
    check("reset rd", 32'(out_rd), 32'd0);
    check("reset value", out_value, 32'd0);
    check("reset misaligned", 32'(out_misaligned), 32'd0);
    @(posedge clock); #3 reset_n = 1'b1;

    // Byte / halfword extraction
    stall_load("lb_a2",  32'h80FF7F01, 3'b000, 2'd2, 5'd1, 0, 32'hFFFFFFFF, 1'b0);
    stall_load("lbu_a3", 32'h80FF7F01, 3'b100, 2'd3, 5'd2, 0, 32'h00000080, 1'b0);
    stall_load("lh_a0",  32'h80017FFE, 3'b001, 2'd0, 5'd3, 0, 32'h00007FFE, 1'b0);
    stall_load("lh_a2",  32'h80017FFE, 3'b001, 2'd2, 5'd4, 0, 32'hFFFF8001, 1'b0);
    stall_load("lhu_a2", 32'h80017FFE, 3'b101, 2'd2, 5'd5, 0, 32'h00008001, 1'b0);
    stall_load("lb_a1",  32'h80FF7F01, 3'b000, 2'd1, 5'd6, 0, 32'h0000007F, 1'b0);
    stall_load("bad_f3", 32'h12345678, 3'b011, 2'd0, 5'd8, 0, 32'h00000000, 1'b0);

    // Stall with the load waiting for writeback
    stall_load("stall3", 32'h13579BDF, 3'b010, 2'd0, 5'd7, 3, 32'h13579BDF, 1'b0);

    // Back-to-back LW
    clear_seq();
    for (int i = 0; i < 4; i++) begin
      sv[i] = 1'b1; sf3[i] = 3'b010; srd[i] = 5'(i + 10); sw[i] = 32'h11111111 * (i + 1);
    end
    run_seq("b2b", 4);

    // Flush with two loads in flight
    clear_seq();
    sv[0] = 1'b1; sf3[0] = 3'b010; srd[0] = 5'd20; sw[0] = 32'hAAAA5555;
    sv[1] = 1'b1; sf3[1] = 3'b010; srd[1] = 5'd21; sw[1] = 32'h5555AAAA;
    sv[2] = 1'b1; sf3[2] = 3'b010; srd[2] = 5'd22; sw[2] = 32'h0F0F0F0F; sfl[2] = 1'b1;
    run_seq("flush", 4);

    // Misaligned LW
`ifdef LOAD_MISALIGN_TRAP_EN
    stall_load("lw_mis", 32'hCAFEBABE, 3'b010, 2'd1, 5'd9, 0, 32'h00000000, 1'b1);
`else
    stall_load("lw_mis", 32'hCAFEBABE, 3'b010, 2'd1, 5'd9, 0, 32'hCAFEBABE, 1'b0);
`endif

    // Randomized streams with occasional flushes
    for (int rr = 0; rr < 4; rr++) begin
      clear_seq();
      for (int i = 0; i < 60; i++) begin
        sv[i]  = ($urandom % 4) != 0;
        sf3[i] = 3'($urandom);
        sal[i] = 2'($urandom);
        srd[i] = 5'($urandom);
        sw[i]  = $urandom();
        sfl[i] = ($urandom % 10) == 0;
      end
      run_seq("rand", 60);
    end

    // Randomized stalled loads
    for (int rr = 0; rr < 8; rr++) begin
      w  = $urandom();
      f3 = 3'($urandom);
      al = 2'($urandom);
      k  = int'($urandom % 4);
      r  = ref_load(w, f3, al);
      stall_load("rand_stall", w, f3, al, 5'($urandom), k, r[31:0], r[32]);
    end

    // Reset mid-pipe
    stall_load("pre_rst", 32'h12345678, 3'b010, 2'd0, 5'd9, 0, 32'h12345678, 1'b0);
    @(posedge clock); #1;
    in_load = 1'b1; in_funct3 = 3'b010; in_addr_low = 2'd0; in_rd = 5'd3;
    @(posedge clock); #1;
    in_rd = 5'd4; mem_read_value = $urandom();
    @(posedge clock); #1;
    in_load = 1'b0; mem_read_value = 32'h87654321;
    #2 reset_n = 1'b0;
    #1;
    check("async rst valid", 32'(out_valid), 32'd0);
    check("async rst rd", 32'(out_rd), 32'd0);
    check("async rst value", out_value, 32'd0);
    check("async rst misaligned", 32'(out_misaligned), 32'd0);
    @(posedge clock);
    @(posedge clock); #3 reset_n = 1'b1;
    last_val = 32'd0;
    for (int t = 0; t < 6; t++) begin
      @(posedge clock); #1;
      mem_read_value = $urandom();
      @(negedge clock);
      check("post rst no stale", 32'(out_valid), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/load_align_stage.md
Name: load_align_stage

Overview:
- Sits directly downstream of stage-4 data memory. The memory returns read data two clock edges after the request.
- This block carries load metadata alongside the memory access so it lines up with the returned word.
- It extracts the byte/halfword/word, sign- or zero-extends it, and registers a writeback result (rd, value) for stage 5.
- It buffers the returned word across stalls, because the memory itself has no enable.

Parameters:
- MEM_LATENCY, 2, edges from request to valid mem_read_value; metadata pipe depth; only 2 supported.
- RD_BITS, 5, destination register index width.

Ports:
- clock  in  1  system clock; all state updates on posedge
- reset_n  in  1  asynchronous active-low reset
- stall  in  1  downstream hold; upstream also holds data memory inputs stable while high
- flush  in  1  kill all in-flight loads
- in_load  in  1  load request issued to data memory this cycle
- in_funct3  in  3  RV32I load funct3
- in_addr_low  in  2  long_addr[1:0] of the request
- in_rd  in  RD_BITS  destination register
- mem_read_value  in  32  data memory read_value
- out_valid  out  1  writeback result valid
- out_rd  out  RD_BITS  writeback register
- out_value  out  32  extended load data
- out_misaligned  out  1  misaligned-load flag (0 unless LOAD_MISALIGN_TRAP_EN)

Behaviour:
- Reset (reset_n low, async): s1/s2 valid=0, hold_valid=0, out_valid=0, out_rd=0, out_value=0, out_misaligned=0. Reset mid-operation discards all in-flight loads; no output results from them after release.
- Metadata pipe: s1 <= {in_load, funct3, addr_low, rd}; s2 <= s1. Both advance only when stall=0.
- Alignment: in the cycle s2 is valid, mem_read_value holds that load's word. out_* register on the next edge. Total latency = 3 edges from in_load to out_valid.
- Hold buffer, first stalled cycle with s2 valid and hold_valid=0: capture hold_data <= mem_read_value, set hold_valid=1.
- Source word = hold_valid ? hold_data : mem_read_value.
- When stall deasserts, out_* load from the source word and hold_valid clears on the same edge.
- stall=1: out_* hold their values; s1/s2 frozen.
- flush=1: s1, s2 and hold valid clear; out_valid <= 0. Flush wins over stall.
- in_load ignored in a flush cycle.
- Extraction: shift = addr_low*8.
  - LB (000): sign-extend byte[shift+7:shift].
  - LH (001): sign-extend half at addr_low[1]*16.
  - LW (010): whole word.
  - LBU (100): zero-extend byte.
  - LHU (101): zero-extend half.
- Other funct3 with s2 valid: out_valid=1, out_value=0.
- Without the feature, misaligned accesses ignore the offending low bits: LH uses addr_low[1] only; LW ignores addr_low.
- out_valid is a one-cycle pulse per load when not stalled; it is held while stalled.
- Back-to-back loads every cycle sustain one result per cycle.

Optional Feature:
- Macro LOAD_MISALIGN_TRAP_EN.
- Defined: LH/LHU with addr_low[0]=1, or LW with addr_low!=0, give out_misaligned=1, out_value=0, out_valid=1 (trap is taken downstream).
- Undefined: out_misaligned tied 0; truncating behaviour as above.

Decomposition:
- Shared package (alongside word/byte definitions): load funct3 constants (LB, LH, LW, LBU, LHU); load_meta_t struct {valid, funct3, addr_low, rd}; RD_BITS default.
- One natural sub-module: load_extend, purely combinational (word, funct3, addr_low -> value, misaligned). It is reused by any future forwarding path.

Test Plan:
- LB reset path: mem word 0x80FF7F01, LB addr_low=2 -> out_value 0xFFFFFFFF, out_valid 3 edges after in_load; LBU addr_low=3 -> 0x00000080.
- LH/LHU: word 0x8001_7FFE, LH addr_low=0 -> 0x00007FFE; LH addr_low=2 -> 0xFFFF8001; LHU addr_low=2 -> 0x00008001.
- Back-to-back: 4 LW on consecutive cycles to words 0x11111111..0x44444444 -> 4 consecutive out_valid pulses in order, correct rd each.
- Stall: assert stall 3 cycles while load in s2, then drive mem_read_value to garbage 0xDEADBEEF -> after release, out_value equals the captured original word, issued exactly once.
- Flush/reset: flush with two loads in flight -> no out_valid for either. Assert reset_n low mid-pipe -> all outputs 0 asynchronously; no stale result after release.
- Feature on: LW addr_low=1 -> out_misaligned=1, out_value=0. Feature off: same stimulus -> out_misaligned=0, out_value=full word.
